// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready handshakes on the load and serial sides.
// Serial data is presented as true and complement outputs; the bit order is set by MSB_FIRST.
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             _reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic             ser_out,
   output logic             ser_nout,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_first,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [0:0]    IDLE     = 1'b0;
   localparam logic [0:0]    SHIFT    = 1'b1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [0:0]       state;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shifted;
   logic [CW-1:0]    bit_cnt;
   logic             first_q;
   logic             done_q;
   logic             last_bit;
   logic             load_fire;

   // bit_cnt counts the bits still to go after the one currently on ser_out
   assign last_bit   = (state == SHIFT) && (bit_cnt == '0);
   assign load_ready = (state == IDLE) || (last_bit && ser_ready);
   assign load_fire  = load_valid && load_ready;

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      shifted = shift_reg;
      if (MSB_FIRST)
         shifted = {shift_reg[WIDTH-2:0], 1'b0};
      else
         shifted = {1'b0, shift_reg[WIDTH-1:1]};
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge _reset) begin
      if (!_reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         first_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load_fire) begin
            // A reload from SHIFT happens only on the last-bit edge, which also completes a word
            if (state == SHIFT)
               done_q <= 1'b1;
            state     <= SHIFT;
            shift_reg <= load_data;
            bit_cnt   <= LAST_CNT;
            first_q   <= 1'b1;
         end else if ((state == SHIFT) && ser_ready) begin
            first_q <= 1'b0;
            if (bit_cnt == '0) begin
               done_q    <= 1'b1;
               state     <= IDLE;
               shift_reg <= '0;
            end else begin
               shift_reg <= shifted;
               bit_cnt   <= bit_cnt - CW'(1);
            end
         end
      end
   end

   assign ser_out   = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
   assign ser_nout  = ~ser_out;
   assign ser_valid = (state == SHIFT);
   assign ser_first = first_q;
   assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: drives an MSB-first and an LSB-first instance with shared stimulus
// and compares both against a queue-of-expected-bits model of the transmitted stream.
module tb_piso_serializer;

   localparam int W = 8;

   typedef struct packed {
      logic b;
      logic f;
   } exp_bit_t;

   logic         clock;
   logic         _reset;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         ser_ready;

   logic lr_m, so_m, sno_m, sv_m, sf_m, dn_m;
   logic lr_l, so_l, sno_l, sv_l, sf_l, dn_l;

   int checks = 0;
   int errors = 0;

   exp_bit_t qm[$];
   exp_bit_t ql[$];
   logic     exp_done = 1'b0;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clock(clock), ._reset(_reset),
      .load_valid(load_valid), .load_ready(lr_m), .load_data(load_data),
      .ser_out(so_m), .ser_nout(sno_m), .ser_valid(sv_m), .ser_ready(ser_ready),
      .ser_first(sf_m), .done(dn_m)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clock(clock), ._reset(_reset),
      .load_valid(load_valid), .load_ready(lr_l), .load_data(load_data),
      .ser_out(so_l), .ser_nout(sno_l), .ser_valid(sv_l), .ser_ready(ser_ready),
      .ser_first(sf_l), .done(dn_l)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values();
      check("rst_m_ser_out",    {7'd0, so_m},  8'd0);
      check("rst_m_ser_nout",   {7'd0, sno_m}, 8'd1);
      check("rst_m_ser_valid",  {7'd0, sv_m},  8'd0);
      check("rst_m_ser_first",  {7'd0, sf_m},  8'd0);
      check("rst_m_done",       {7'd0, dn_m},  8'd0);
      check("rst_m_load_ready", {7'd0, lr_m},  8'd1);
      check("rst_l_ser_out",    {7'd0, so_l},  8'd0);
      check("rst_l_ser_nout",   {7'd0, sno_l}, 8'd1);
      check("rst_l_ser_valid",  {7'd0, sv_l},  8'd0);
      check("rst_l_load_ready", {7'd0, lr_l},  8'd1);
   endtask

   task automatic check_one(input string name, input logic so, input logic sno, input logic sv,
                            input logic sf, input logic dn, input logic lr,
                            input int qsize, input exp_bit_t front);
      logic exp_lr;
      exp_lr = (qsize == 0) || (qsize == 1 && ser_ready);
      check({name, "_ser_valid"},  {7'd0, sv},  {7'd0, qsize != 0});
      check({name, "_ser_out"},    {7'd0, so},  {7'd0, (qsize != 0) ? front.b : 1'b0});
      check({name, "_ser_first"},  {7'd0, sf},  {7'd0, (qsize != 0) ? front.f : 1'b0});
      check({name, "_ser_nout"},   {7'd0, sno}, {7'd0, ~so});
      check({name, "_done"},       {7'd0, dn},  {7'd0, exp_done});
      check({name, "_load_ready"}, {7'd0, lr},  {7'd0, exp_lr});
   endtask

   // Model: a word accepted by the load handshake becomes W queued bits in transmit order;
   // each serial handshake removes one, and removing the final bit of a word raises done.
   task automatic model_edge(input logic lv, input logic [W-1:0] ld, input logic sr);
      logic accept;
      accept   = (qm.size() == 0) || (qm.size() == 1 && sr);
      exp_done = 1'b0;
      if (qm.size() != 0 && sr) begin
         if (qm.size() == 1) exp_done = 1'b1;
         void'(qm.pop_front());
         void'(ql.pop_front());
      end
      if (lv && accept) begin
         for (int i = 0; i < W; i++) begin
            qm.push_back('{b: ld[W-1-i], f: (i == 0)});
            ql.push_back('{b: ld[i],     f: (i == 0)});
         end
      end
   endtask

   task automatic cycle(input logic lv, input logic [W-1:0] ld, input logic sr);
      load_valid = lv;
      load_data  = ld;
      ser_ready  = sr;
      #1;
      check_one("msb", so_m, sno_m, sv_m, sf_m, dn_m, lr_m, qm.size(),
                (qm.size() != 0) ? qm[0] : exp_bit_t'('0));
      check_one("lsb", so_l, sno_l, sv_l, sf_l, dn_l, lr_l, ql.size(),
                (ql.size() != 0) ? ql[0] : exp_bit_t'('0));
      @(posedge clock);
      model_edge(lv, ld, sr);
      #1;
   endtask

   // Asserts reset between clock edges, checks outputs respond without an edge, then releases.
   task automatic mid_cycle_reset();
      load_valid = 1'b0;
      ser_ready  = 1'b1;
      #3;
      _reset = 1'b0;
      #1;
      check_reset_values();
      qm.delete();
      ql.delete();
      exp_done = 1'b0;
      @(posedge clock);
      #2;
      check_reset_values();
      _reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] word);
      cycle(1'b1, word, 1'b1);
      for (int i = 0; i < W; i++) cycle(1'b0, W'($urandom), 1'b1);
      cycle(1'b0, W'($urandom), 1'b1);
   endtask

   initial begin
      _reset     = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      ser_ready  = 1'b0;
      #2;
      check_reset_values();
      #10;
      _reset = 1'b1;
      @(posedge clock);
      #1;

      // Single word, continuous consumer: A5 MSB-first and LSB-first
      send_word(8'hA5);

      // Stall three cycles while the third bit is on the line
      cycle(1'b1, 8'hA5, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 8'h00, 1'b0);
         check("stall_ser_out",   {7'd0, so_m}, 8'd1);
         check("stall_ser_valid", {7'd0, sv_m}, 8'd1);
      end
      for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1);

      // Back-to-back words with load_valid held high
      cycle(1'b1, 8'hFF, 1'b1);
      for (int i = 0; i < 8; i++) cycle(1'b1, 8'h00, 1'b1);
      for (int i = 0; i < 9; i++) cycle(1'b0, 8'h55, 1'b1);

      // Reset part-way through F0, then a clean 3C
      cycle(1'b1, 8'hF0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
      mid_cycle_reset();
      cycle(1'b0, 8'h00, 1'b1);
      send_word(8'h3C);

      // LSB-first single set bit, plus a mid-word reset on another word
      send_word(8'h01);
      cycle(1'b1, 8'h96, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);
      mid_cycle_reset();

      // Randomized traffic on both handshakes
      for (int i = 0; i < 400; i++)
         cycle(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 3) != 0));
      for (int i = 0; i < 12; i++) cycle(1'b0, W'($urandom), 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
